// File: rtl/lsu_pkg.sv
// lsu_pkg: shared funct3 codes, FSM states and legality helpers for the load/store unit
package lsu_pkg;
   localparam logic [2:0] F3_B  = 3'd0;
   localparam logic [2:0] F3_H  = 3'd1;
   localparam logic [2:0] F3_W  = 3'd2;
   localparam logic [2:0] F3_BU = 3'd4;
   localparam logic [2:0] F3_HU = 3'd5;
   typedef enum logic [1:0] {IDLE, RD, WR, RESP} lsu_state_t;
   function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
      return ((f3 == F3_H || f3 == F3_HU) && a[0]) || (f3 == F3_W && a != 2'b00);
   endfunction
   function automatic logic is_illegal(input logic [2:0] f3, input logic we);
      return !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU}) || (we && (f3 == F3_BU || f3 == F3_HU));
   endfunction
endpackage

// File: rtl/lsu_mem_master_if.sv
// lsu_mem_master_if: request/response handshake and data-memory port of the load/store unit
interface lsu_mem_master_if #(parameter int DATA_W = 32, ADDR_W = 32, DM_ADDRESS = 12);
   logic req_valid, req_ready, req_we;
   logic [2:0] req_funct3;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic resp_valid, resp_err;
   logic [DATA_W-1:0] resp_rdata;
   logic dm_read, dm_write;
   logic [DM_ADDRESS-1:0] dm_addr;
   logic [DATA_W-1:0] dm_wd, dm_rd;
   modport master(input req_valid, req_we, req_funct3, req_addr, req_wdata, dm_rd,
                  output req_ready, resp_valid, resp_err, resp_rdata, dm_read, dm_write, dm_addr, dm_wd);
   modport slave(output req_valid, req_we, req_funct3, req_addr, req_wdata, dm_rd,
                 input req_ready, resp_valid, resp_err, resp_rdata, dm_read, dm_write, dm_addr, dm_wd);
endinterface

// File: rtl/lsu_align.sv
// lsu_align: load byte/half extraction with sign/zero extension and store lane merge
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  off,
   input  logic [31:0] rd_word,
   input  logic [31:0] cur_word,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] store_word
);
   logic [7:0] b;
   logic [15:0] h;
   always_comb begin
      b = rd_word[{off, 3'b000} +: 8];
      h = rd_word[{off[1], 4'b0000} +: 16];
      load_data = funct3 == F3_B  ? {{24{b[7]}}, b} :
                  funct3 == F3_BU ? {24'b0, b} :
                  funct3 == F3_H  ? {{16{h[15]}}, h} :
                  funct3 == F3_HU ? {16'b0, h} : rd_word;
      store_word = funct3 == F3_W ? wdata : cur_word;
      if (funct3 == F3_B) store_word[{off, 3'b000} +: 8] = wdata[7:0];
      if (funct3 == F3_H) store_word[{off[1], 4'b0000} +: 16] = wdata[15:0];
   end
endmodule

// File: rtl/lsu_mem_master.sv
// lsu_mem_master: one-at-a-time load/store FSM with read-modify-write sub-word stores
module lsu_mem_master
   import lsu_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32,
   parameter int DM_ADDRESS = 12
) (
   input logic clk,
   input logic rst,
   lsu_mem_master_if.master bus
);
   lsu_state_t state, state_n;
   logic we_q, err_n, err_q, accept;
   logic [2:0] f3_q;
   logic [DM_ADDRESS+1:0] addr_q;
   logic [DATA_W-1:0] wdata_q, data_q, rdata_q, load_data, store_word;
   assign accept = bus.req_valid && bus.req_ready;
   always_comb begin
      state_n = state;
      err_n = 1'b0;
      case (state)
         IDLE: if (accept) begin
            err_n = is_illegal(bus.req_funct3, bus.req_we) || is_misaligned(bus.req_funct3, bus.req_addr[1:0]);
            state_n = err_n ? RESP : (bus.req_we && bus.req_funct3 == F3_W) ? WR : RD;
         end
         RD:      state_n = we_q ? WR : RESP;
         WR:      state_n = RESP;
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         we_q    <= 1'b0;
         f3_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         data_q  <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state <= state_n;
         if (accept) begin
            we_q    <= bus.req_we;
            f3_q    <= bus.req_funct3;
            addr_q  <= bus.req_addr[DM_ADDRESS+1:0];
            wdata_q <= bus.req_wdata;
         end
         if (state == RD) data_q <= bus.dm_rd;
         // Load data is extracted straight from the memory port so RESP needs no extra cycle
         if (state_n == RESP && state != RESP) begin
            err_q   <= err_n;
            rdata_q <= (state == RD && !we_q) ? load_data : '0;
         end
      end
   end
   lsu_align u_align (
      .funct3    (f3_q),
      .off       (addr_q[1:0]),
      .rd_word   (bus.dm_rd),
      .cur_word  (data_q),
      .wdata     (wdata_q),
      .load_data (load_data),
      .store_word(store_word)
   );
   assign bus.req_ready  = state == IDLE && !rst;
   assign bus.resp_valid = state == RESP && !rst;
   assign bus.resp_err   = err_q;
   assign bus.resp_rdata = rdata_q;
   assign bus.dm_read    = state == RD && !rst;
   assign bus.dm_write   = state == WR && !rst;
   assign bus.dm_addr    = addr_q[DM_ADDRESS+1:2];
   assign bus.dm_wd      = state == WR ? store_word : '0;
endmodule
